ex_result_stage: RTL and testbench

EX_RESULT_STAGE -- requirements
Module: ex_result_stage

---
 rtl/ex_result_stage.sv | 45 ++++
 tb/tb_ex_result_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ex_result_stage.sv
// ex_result_stage: EX->MEM result register with NZCV flag register, bypass and flag-update counter
module ex_result_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_result,
    input  logic        in_negative,
    input  logic        in_zero,
    input  logic        in_carry,
    input  logic        in_overflow,
    input  logic        set_flags,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [63:0] out_result,
    output logic [3:0]  flags,
    output logic [3:0]  flags_next,
    output logic [15:0] flag_writes
);
    logic       upd;
    logic [3:0] in_flags;
    always_comb begin
        in_flags   = {in_negative, in_zero, in_carry, in_overflow};
        upd        = in_valid & set_flags & ~stall & ~flush & ~reset;
        flags_next = upd ? in_flags : flags;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_result  <= 64'h0;
            flags       <= 4'b0000;
            flag_writes <= 16'h0000;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_result <= 64'h0;
        end else if (!stall) begin
            out_valid  <= in_valid;
            out_result <= in_result;
            if (upd) begin
                flags       <= in_flags;
                flag_writes <= flag_writes + 16'h1;
            end
        end
    end
endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage: directed and randomized checks of ex_result_stage against a cycle-level reference model
module tb_ex_result_stage;
    logic        clk = 0;
    logic        reset = 0, in_valid = 0, set_flags = 0, stall = 0, flush = 0;
    logic [63:0] in_result = 0;
    logic [3:0]  in_nzcv = 0;
    logic        out_valid;
    logic [63:0] out_result;
    logic [3:0]  flags, flags_next;
    logic [15:0] flag_writes;
    int          total = 0, bad = 0;
    logic        mv  = 'x;
    logic [63:0] mr  = 'x;
    logic [3:0]  mf  = 'x;
    logic [15:0] mc  = 'x;

    always #5 clk = ~clk;

    ex_result_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_result(in_result),
        .in_negative(in_nzcv[3]), .in_zero(in_nzcv[2]), .in_carry(in_nzcv[1]), .in_overflow(in_nzcv[0]),
        .set_flags(set_flags), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_result(out_result), .flags(flags),
        .flags_next(flags_next), .flag_writes(flag_writes)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] r, input logic [3:0] nzcv,
                         input logic sf, input logic st, input logic fl, input logic rs);
        @(negedge clk);
        in_valid = v; in_result = r; in_nzcv = nzcv;
        set_flags = sf; stall = st; flush = fl; reset = rs;
    endtask

    // One clock: check the bypass before the edge, advance the model, check registers after it.
    task automatic step(input bit full = 1);
        bit commit;
        commit = in_valid && set_flags && !stall && !flush && !reset;
        #1;
        if (full) chk("flags_next", {60'h0, flags_next}, {60'h0, commit ? in_nzcv : mf});
        @(posedge clk);
        if (reset) begin
            mv = 0; mr = 0; mf = 0; mc = 0;
        end else if (flush) begin
            mv = 0; mr = 0;
        end else if (!stall) begin
            mv = in_valid; mr = in_result;
            if (commit) begin
                mf = in_nzcv;
                mc = mc + 1;
            end
        end
        #1;
        if (full) begin
            chk("out_valid", {63'h0, out_valid}, {63'h0, mv});
            chk("out_result", out_result, mr);
            chk("flags", {60'h0, flags}, {60'h0, mf});
            chk("flag_writes", {48'h0, flag_writes}, {48'h0, mc});
        end
    endtask

    initial begin
        drive(1, 64'h1234, 4'hF, 1, 1, 1, 1); step();
        chk("reset_valid", {63'h0, out_valid}, 64'h0);
        chk("reset_cnt", {48'h0, flag_writes}, 64'h0);
        // first flag-setting result
        drive(1, '1, 4'b1000, 1, 0, 0, 0);
        #1 chk("bypass_first", {60'h0, flags_next}, 64'h8);
        step();
        chk("first_flags", {60'h0, flags}, 64'h8);
        chk("first_cnt", {48'h0, flag_writes}, 64'h1);
        // non-flag-setting result leaves NZCV alone
        drive(1, 64'h0, 4'b0100, 0, 0, 0, 0); step();
        chk("noset_flags", {60'h0, flags}, 64'h8);
        // stall holds a loaded result
        drive(1, 64'h8000_0000_0000_0000, 4'b0001, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'(i + 5), 4'b0110, 1, 1, 0, 0); step();
            chk("stall_hold", out_result, 64'h8000_0000_0000_0000);
        end
        drive(1, 64'hABCD, 4'b0010, 1, 0, 0, 0); step();
        chk("stall_release", out_result, 64'hABCD);
        // flush dominates stall
        drive(1, 64'h55, 4'b0100, 1, 1, 1, 0); step();
        chk("flush_valid", {63'h0, out_valid}, 64'h0);
        chk("flush_flags", {60'h0, flags}, 64'h2);
        // reset discards a stalled result
        drive(1, 64'h77, 4'b0000, 0, 0, 0, 0); step();
        drive(1, 64'h99, 4'b1111, 1, 1, 0, 1); step();
        chk("reset_over_stall", {63'h0, out_valid}, 64'h0);
        // reset beats a flag update
        drive(1, 64'h42, 4'b1111, 1, 0, 0, 0); step();
        drive(1, 64'h43, 4'b1010, 1, 0, 0, 1);
        #1 chk("reset_bypass", {60'h0, flags_next}, {60'h0, flags});
        step();
        chk("reset_over_load", {48'h0, flag_writes}, 64'h0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 4'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
            step();
        end
        // counter wrap
        drive(0, 0, 0, 0, 0, 0, 1); step();
        for (int i = 0; i < 65535; i++) begin
            drive(1, 64'(i), 4'(i), 1, 0, 0, 0); step(0);
        end
        chk("preload_cnt", {48'h0, flag_writes}, 64'hFFFF);
        drive(1, 64'h1, 4'b0101, 1, 0, 0, 0); step();
        chk("wrap_cnt", {48'h0, flag_writes}, 64'h0);
        chk("wrap_flags", {60'h0, flags}, 64'h5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
